txn_dispatcher: RTL

//  Parametrised front-end transaction controller between the RNIC and NUM_BANKS bank schedulers.

---
 rtl/types_def.sv | 9 +
 rtl/rd_reorder_buf.sv | 104 ++++++++++
 rtl/txn_dispatcher.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/types_def.sv
// Types shared between the transaction dispatcher and its read reorder buffer.
package types_def;

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_type_e;

endpackage

// File: rtl/rd_reorder_buf.sv
// Read reorder buffer: hands out tags in order, collects out-of-order completions
// and retires them one per cycle in tag order.
module rd_reorder_buf #(
    parameter  int DATA_WIDTH = 32,
    parameter  int TAG_DEPTH  = 64,
    localparam int TAG_W      = $clog2(TAG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_i,
    output logic [TAG_W-1:0]      head_o,
    output logic                  full_o,
    input  logic                  cpl_i,
    input  logic [TAG_W-1:0]      cpl_tag_i,
    input  logic [DATA_WIDTH-1:0] cpl_data_i,
    output logic                  retire_o,
    output logic [DATA_WIDTH-1:0] retire_data_o
);

    logic [TAG_W-1:0]      head_q, head_d;
    logic [TAG_W-1:0]      tail_q, tail_d;
    logic [TAG_W:0]        cnt_q, cnt_d;
    logic [TAG_DEPTH-1:0]  alloc_vec;
    logic [TAG_DEPTH-1:0]  done_vec;
    logic [DATA_WIDTH-1:0] mem_q [TAG_DEPTH];
    logic                  retire_q;
    logic [DATA_WIDTH-1:0] retire_data_q;
    logic                  retire;
    logic                  cpl_ok;

    assign retire = done_vec[tail_q];
    // Completions for unallocated or already-completed tags are dropped without side effects.
    assign cpl_ok = cpl_i && alloc_vec[cpl_tag_i] && !done_vec[cpl_tag_i];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + (TAG_W+1)'(alloc_i) - (TAG_W+1)'(retire);
        if (alloc_i) begin
            head_d = head_q + TAG_W'(1);
        end
        if (retire) begin
            tail_d = tail_q + TAG_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TAG_DEPTH; gi++) begin : g_entry
            logic alloc_bit_q;
            logic done_bit_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    alloc_bit_q <= 1'b0;
                    done_bit_q  <= 1'b0;
                end else if (retire && tail_q == TAG_W'(gi)) begin
                    alloc_bit_q <= 1'b0;
                    done_bit_q  <= 1'b0;
                end else begin
                    if (alloc_i && head_q == TAG_W'(gi)) begin
                        alloc_bit_q <= 1'b1;
                    end
                    if (cpl_ok && cpl_tag_i == TAG_W'(gi)) begin
                        done_bit_q <= 1'b1;
                    end
                end
            end

            assign alloc_vec[gi] = alloc_bit_q;
            assign done_vec[gi]  = done_bit_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (cpl_ok) begin
            mem_q[cpl_tag_i] <= cpl_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            cnt_q         <= '0;
            retire_q      <= 1'b0;
            retire_data_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            retire_q <= retire;
            if (retire) begin
                retire_data_q <= mem_q[tail_q];
            end
        end
    end

    assign head_o        = head_q;
    assign full_o        = (cnt_q == (TAG_W+1)'(TAG_DEPTH));
    assign retire_o      = retire_q;
    assign retire_data_o = retire_data_q;

endmodule

// File: rtl/txn_dispatcher.sv
// Front-end transaction dispatcher: one-entry output register to the banks,
// read/write credit gating, and in-order read return via the reorder buffer.
module txn_dispatcher
    import types_def::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDR_WIDTH   = 32,
    parameter  int NUM_BANKS    = 16,
    parameter  int BANK_SEL_LSB = 6,
    parameter  int TAG_DEPTH    = 64,
    parameter  int MAX_WRITES   = 64,
    localparam int BANK_BITS    = $clog2(NUM_BANKS),
    localparam int TAG_W        = $clog2(TAG_DEPTH),
    localparam int WCNT_W       = $clog2(MAX_WRITES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_type,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_busy,
    output logic [NUM_BANKS-1:0]  req_valid,
    output logic                  req_type,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [TAG_W-1:0]      req_tag,
    input  logic [NUM_BANKS-1:0]  bank_busy,
    input  logic                  cpl_valid,
    input  logic                  cpl_type,
    input  logic [TAG_W-1:0]      cpl_tag,
    input  logic [DATA_WIDTH-1:0] cpl_data,
    output logic                  rd_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_done
);

    txn_type_e             in_kind;
    txn_type_e             cpl_kind;
    logic [BANK_BITS-1:0]  bank_sel;
    logic [NUM_BANKS-1:0]  bank_onehot;

    logic [NUM_BANKS-1:0]  req_valid_q, req_valid_d;
    txn_type_e             req_type_q, req_type_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [TAG_W-1:0]      req_tag_q, req_tag_d;
    logic [WCNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic                  wr_done_q;

    logic                  drain;
    logic                  can_take;
    logic                  rd_full;
    logic                  wr_full;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  wr_cpl_ok;
    logic [TAG_W-1:0]      rd_head;

    assign in_kind  = txn_type_e'(in_type);
    assign cpl_kind = txn_type_e'(cpl_type);
    assign bank_sel = in_addr[BANK_SEL_LSB +: BANK_BITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign bank_onehot[gi] = (bank_sel == BANK_BITS'(gi));
        end
    endgenerate

    // A held request that drains this edge frees the register for a same-cycle accept.
    assign drain    = |(req_valid_q & ~bank_busy);
    assign can_take = ~|req_valid_q | drain;
    assign wr_full  = (wr_cnt_q == WCNT_W'(MAX_WRITES));
    assign out_busy = in_valid & (~can_take
                                  | ((in_kind == TXN_READ)  & rd_full)
                                  | ((in_kind == TXN_WRITE) & wr_full));
    assign accept    = in_valid & ~out_busy;
    assign rd_accept = accept & (in_kind == TXN_READ);
    assign wr_accept = accept & (in_kind == TXN_WRITE);
    assign wr_cpl_ok = cpl_valid & (cpl_kind == TXN_WRITE) & (wr_cnt_q != '0);

    always_comb begin
        req_valid_d = req_valid_q;
        req_type_d  = req_type_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_tag_d   = req_tag_q;
        if (accept) begin
            req_valid_d = bank_onehot;
            req_type_d  = in_kind;
            req_addr_d  = in_addr;
            req_data_d  = in_data;
            req_tag_d   = (in_kind == TXN_READ) ? rd_head : '0;
        end else if (drain) begin
            req_valid_d = '0;
        end
    end

    assign wr_cnt_d = wr_cnt_q + WCNT_W'(wr_accept) - WCNT_W'(wr_cpl_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= '0;
            req_type_q  <= TXN_READ;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_tag_q   <= '0;
            wr_cnt_q    <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_type_q  <= req_type_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_tag_q   <= req_tag_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_done_q   <= wr_cpl_ok;
        end
    end

    rd_reorder_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_DEPTH  (TAG_DEPTH)
    ) u_rob (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (rd_accept),
        .head_o        (rd_head),
        .full_o        (rd_full),
        .cpl_i         (cpl_valid & (cpl_kind == TXN_READ)),
        .cpl_tag_i     (cpl_tag),
        .cpl_data_i    (cpl_data),
        .retire_o      (rd_done),
        .retire_data_o (rd_data)
    );

    assign req_valid = req_valid_q;
    assign req_type  = req_type_q;
    assign req_addr  = req_addr_q;
    assign req_data  = req_data_q;
    assign req_tag   = req_tag_q;
    assign wr_done   = wr_done_q;

endmodule
